// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined RISC-V core.
// Captures decoded operands and control one cycle after Decode, detects
// load-use hazards (stalling PC and IF/ID), forwards a same-cycle writeback
// into the captured operands, inserts bubbles on stall or flush, and keeps
// saturating stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_e,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              stall_fd,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Everything Execute sees, held as one register so a bubble is a single '0.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             bubble;

  // x0 reads as zero; otherwise a writeback landing this cycle beats the
  // register file value, which has not been updated yet.
  function automatic logic [XLEN-1:0] operand(input logic [4:0]      rs,
                                              input logic [XLEN-1:0] rf_val);
    if (rs == 5'd0)
      return '0;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return wb_data;
    else
      return rf_val;
  endfunction

  // Load in EX whose destination is a source of the instruction in ID.
  assign stall_fd = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

  assign bubble = flush_e || stall_fd;

  // Next EX contents: a full bubble, or the Decode fields with forwarded operands.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this purely
    // combinational; a path that leaves a field unassigned would infer a latch.
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid     = id_valid;
      ex_d.reg_write = id_valid && id_reg_write;
      ex_d.mem_read  = id_valid && id_mem_read;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.rd1       = operand(id_rs1, id_rd1);
      ex_d.rd2       = operand(id_rs2, id_rd2);
      ex_d.imm       = id_imm;
      ex_d.pc        = id_pc;
      ex_d.ctrl      = id_ctrl;
    end
  end

  // Saturating event counters; a flush takes the credit when both happen.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_fd && !flush_e && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_e && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Pipeline and counter state; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, so ordering between these lines cannot matter.
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_rd1       = ex_q.rd1;
  assign ex_rd2       = ex_q.rd2;
  assign ex_imm       = ex_q.imm;
  assign ex_pc        = ex_q.pc;
  assign ex_ctrl      = ex_q.ctrl;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall, writeback bypass,
// flush priority, counter saturation (narrow-counter instance) and async reset.
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_e;
  logic              id_valid;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0]   id_rd1, id_rd2, id_imm, id_pc;
  logic              id_reg_write, id_mem_read;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              stall_fd, ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0]   ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  // Narrow-counter instance, sharing all inputs, used for saturation.
  logic              n_stall_fd, n_ex_valid, n_ex_reg_write, n_ex_mem_read;
  logic [4:0]        n_ex_rs1, n_ex_rs2, n_ex_rd;
  logic [XLEN-1:0]   n_ex_rd1, n_ex_rd2, n_ex_imm, n_ex_pc;
  logic [CTRL_W-1:0] n_ex_ctrl;
  logic [1:0]        n_stall_cnt, n_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_e(flush_e), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_fd(stall_fd), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(2)) dut_narrow (
    .clk(clk), .rst(rst), .flush_e(flush_e), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_fd(n_stall_fd), .ex_valid(n_ex_valid), .ex_reg_write(n_ex_reg_write),
    .ex_mem_read(n_ex_mem_read), .ex_rs1(n_ex_rs1), .ex_rs2(n_ex_rs2), .ex_rd(n_ex_rd),
    .ex_rd1(n_ex_rd1), .ex_rd2(n_ex_rd2), .ex_imm(n_ex_imm), .ex_pc(n_ex_pc),
    .ex_ctrl(n_ex_ctrl), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_e = 1'b0; id_valid = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_pc = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_ctrl = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  // Drive a valid load writing register rd.
  task automatic drive_load(input logic [4:0] rd);
    idle_inputs();
    id_valid = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; id_rd = rd;
    id_pc = 32'h100; id_imm = 32'h4; id_ctrl = 8'h11;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      flush_e = 1'($urandom); id_valid = 1'($urandom);
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
      id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc = $urandom;
      id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_ctrl = 8'($urandom);
      wb_we = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
      tick();
      n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b%b required 000", ex_valid, ex_reg_write, ex_mem_read); end
      n_checks++; if (ex_rd1 !== '0 || ex_rd2 !== '0 || ex_imm !== '0 || ex_pc !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h required all 0", ex_rd1, ex_rd2, ex_imm, ex_pc); end
      n_checks++; if (ex_rs1 !== '0 || ex_rs2 !== '0 || ex_rd !== '0 || ex_ctrl !== '0) begin n_fail++; $display("FAIL reset_regs: got %h %h %h ctrl %h required all 0", ex_rs1, ex_rs2, ex_rd, ex_ctrl); end
      n_checks++; if (stall_cnt !== '0 || flush_cnt !== '0 || stall_fd !== 1'b0) begin n_fail++; $display("FAIL reset_cnt: got stall_cnt %0d flush_cnt %0d stall_fd %b required 0 0 0", stall_cnt, flush_cnt, stall_fd); end
    end
    rst = 1'b0;
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd1; id_rd1 = 32'd10; id_rd = 5'd3;
    id_pc = 32'h40; id_imm = 32'h7; id_ctrl = 8'hA5; id_reg_write = 1'b1;
    tick();
    n_checks++; if (ex_rd1 !== 32'd10 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL first_capture: got rd1 %0d valid %b required 10 1", ex_rd1, ex_valid); end
    n_checks++; if (ex_pc !== 32'h40 || ex_imm !== 32'h7 || ex_ctrl !== 8'hA5 || ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin n_fail++; $display("FAIL first_fields: got pc %h imm %h ctrl %h rd %0d rw %b required 40 7 a5 3 1", ex_pc, ex_imm, ex_ctrl, ex_rd, ex_reg_write); end
  endtask

  task automatic test_load_use();
    drive_load(5'd5);
    tick();
    n_checks++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd5) begin n_fail++; $display("FAIL load_in_ex: got mem_read %b rd %0d required 1 5", ex_mem_read, ex_rd); end
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd5; id_rd = 5'd6; id_reg_write = 1'b1;
    id_rd1 = 32'd33; id_rd2 = 32'd55; id_ctrl = 8'h3C;
    #1;
    n_checks++; if (stall_fd !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b required 1", stall_fd); end
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0 || ex_rd2 !== '0) begin n_fail++; $display("FAIL stall_bubble: got v %b rw %b mr %b ctrl %h rd %0d rd2 %0d required all 0", ex_valid, ex_reg_write, ex_mem_read, ex_ctrl, ex_rd, ex_rd2); end
    n_checks++; if (stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_count: got %0d/%0d required 1/0", stall_cnt, flush_cnt); end
    n_checks++; if (stall_fd !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b required 0", stall_fd); end
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rs2 !== 5'd5 || ex_rd2 !== 32'd55 || ex_ctrl !== 8'h3C) begin n_fail++; $display("FAIL held_capture: got v %b rd %0d rs2 %0d rd2 %0d ctrl %h required 1 6 5 55 3c", ex_valid, ex_rd, ex_rs2, ex_rd2, ex_ctrl); end
    // Load targeting x0 never stalls, even against a source of x0.
    drive_load(5'd0);
    tick();
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd4; id_rd = 5'd8;
    #1;
    n_checks++; if (stall_fd !== 1'b0) begin n_fail++; $display("FAIL x0_no_stall: got %b required 0", stall_fd); end
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || stall_cnt !== 16'd1) begin n_fail++; $display("FAIL x0_capture: got v %b rd %0d stall_cnt %0d required 1 8 1", ex_valid, ex_rd, stall_cnt); end
  endtask

  task automatic test_wb_bypass();
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd1; id_rd1 = 32'd10; id_rd2 = 32'd10;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd20;
    tick();
    n_checks++; if (ex_rd1 !== 32'd20 || ex_rd2 !== 32'd20) begin n_fail++; $display("FAIL bypass_hit: got %0d %0d required 20 20", ex_rd1, ex_rd2); end
    wb_we = 1'b0;
    tick();
    n_checks++; if (ex_rd1 !== 32'd10 || ex_rd2 !== 32'd10) begin n_fail++; $display("FAIL bypass_we0: got %0d %0d required 10 10", ex_rd1, ex_rd2); end
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd30; id_rs1 = 5'd0;
    tick();
    n_checks++; if (ex_rd1 !== 32'd0 || ex_rd2 !== 32'd10) begin n_fail++; $display("FAIL bypass_x0: got %0d %0d required 0 10", ex_rd1, ex_rd2); end
    wb_rd = 5'd2; id_rs1 = 5'd2; id_rs2 = 5'd3; id_rd1 = 32'd11; id_rd2 = 32'd12; wb_data = 32'd99;
    tick();
    n_checks++; if (ex_rd1 !== 32'd99 || ex_rd2 !== 32'd12) begin n_fail++; $display("FAIL bypass_one_side: got %0d %0d required 99 12", ex_rd1, ex_rd2); end
    // Not-valid slot still captures fields but drops its effects.
    idle_inputs();
    id_rd = 5'd9; id_reg_write = 1'b1; id_mem_read = 1'b1; id_pc = 32'h88; id_ctrl = 8'h5A;
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== 5'd9 || ex_pc !== 32'h88 || ex_ctrl !== 8'h5A) begin n_fail++; $display("FAIL invalid_capture: got v %b rw %b mr %b rd %0d pc %h ctrl %h required 0 0 0 9 88 5a", ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_pc, ex_ctrl); end
    n_checks++; if (stall_cnt !== 16'd1 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL invalid_counts: got %0d/%0d required 1/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_flush_priority();
    drive_load(5'd7);
    tick();
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd7; id_rd = 5'd2; id_reg_write = 1'b1; flush_e = 1'b1;
    #1;
    n_checks++; if (stall_fd !== 1'b1) begin n_fail++; $display("FAIL flush_stall_seen: got %b required 1", stall_fd); end
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== '0) begin n_fail++; $display("FAIL flush_bubble: got v %b rw %b rd %0d required 0 0 0", ex_valid, ex_reg_write, ex_rd); end
    n_checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_counts: got flush %0d stall %0d required 1 1", flush_cnt, stall_cnt); end
    flush_e = 1'b0;
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd2 || flush_cnt !== 16'd1) begin n_fail++; $display("FAIL after_flush: got v %b rd %0d flush %0d required 1 2 1", ex_valid, ex_rd, flush_cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_narrow [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    flush_e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (n_flush_cnt !== exp_narrow[i]) begin n_fail++; $display("FAIL sat_narrow[%0d]: got %0d required %0d", i, n_flush_cnt, exp_narrow[i]); end
      n_checks++; if (flush_cnt !== 16'(i + 1)) begin n_fail++; $display("FAIL sat_wide[%0d]: got %0d required %0d", i, flush_cnt, i + 1); end
    end
    flush_e = 1'b0;
    tick();
    n_checks++; if (n_flush_cnt !== 2'd3 || n_stall_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_hold: got flush %0d stall %0d required 3 0", n_flush_cnt, n_stall_cnt); end
  endtask

  task automatic test_async_reset_mid_stall();
    drive_load(5'd5);
    tick();
    idle_inputs();
    id_valid = 1'b1; id_rs2 = 5'd5; id_rd = 5'd4; id_rd2 = 32'd77;
    #1;
    n_checks++; if (stall_fd !== 1'b1) begin n_fail++; $display("FAIL mid_stall_setup: got %b required 1", stall_fd); end
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== '0 || ex_pc !== '0 || stall_fd !== 1'b0) begin n_fail++; $display("FAIL async_clear: got v %b mr %b rd %0d pc %h stall %b required 0 0 0 0 0", ex_valid, ex_mem_read, ex_rd, ex_pc, stall_fd); end
    n_checks++; if (flush_cnt !== '0 || stall_cnt !== '0) begin n_fail++; $display("FAIL async_cnt: got flush %0d stall %0d required 0 0", flush_cnt, stall_cnt); end
    rst = 1'b0;
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_rd2 !== 32'd77 || stall_cnt !== '0) begin n_fail++; $display("FAIL post_reset_capture: got v %b rd %0d rd2 %0d stall_cnt %0d required 1 4 77 0", ex_valid, ex_rd, ex_rd2, stall_cnt); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_wb_bypass();
    test_flush_priority();
    test_saturation();
    test_async_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
